// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths and requantization helper for the conv output path
package conv_pkg;

    localparam int DEF_ACC_W = 39;
    localparam int DEF_FRAC  = 16;
    localparam int DEF_OUT_W = 8;

    // Round half up, arithmetic shift, then clamp to the signed or ReLU range.
    // 64-bit working width holds any accumulator up to 63 bits without overflow.
    function automatic logic [15:0] sat_round(input logic signed [63:0] acc,
                                              input int frac,
                                              input int out_w,
                                              input logic relu);
        logic signed [63:0] r;
        logic signed [63:0] lo;
        logic signed [63:0] hi;
        r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        if (relu) begin
            lo = 64'sd0;
            hi = (64'sd1 <<< out_w) - 64'sd1;
        end else begin
            lo = -(64'sd1 <<< (out_w - 1));
            hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        end
        if (r < lo) begin
            r = lo;
        end else if (r > hi) begin
            r = hi;
        end
        return r[15:0];
    endfunction

endpackage

// File: rtl/conv_drain_fifo.sv
// rtl/conv_drain_fifo.sv - first-word-fall-through pixel FIFO with occupancy count
module conv_drain_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          push_drop
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok    = pop && (count != '0);
    // A full FIFO still takes a word when the same cycle frees a slot.
    assign push_ok   = push && ((count < DEPTH_C) || pop_ok);
    assign push_drop = push && !push_ok;
    assign rd_data   = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_result_drain.sv
// rtl/conv_result_drain.sv - credit, requant, buffering and framing for conv core results
module conv_result_drain
    import conv_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAC      = DEF_FRAC,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int DEPTH     = 16,
    parameter int FRAME_PIX = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    output logic             issue_ready,
    input  logic [ACC_W-1:0] acc_in,
    input  logic             acc_valid,
    input  logic             relu_en,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             err_ovf,
    output logic             err_proto
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [FW-1:0] LAST_C  = FW'(FRAME_PIX - 1);

    logic [CW-1:0]    inflight;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      credit_used;
    logic [CW:0]      infl_next;
    logic             q_valid;
    logic [OUT_W-1:0] q_data;
    logic [15:0]      rq;
    logic             pop;
    logic             drop;
    logic [FW-1:0]    pix_cnt;

    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign issue_ready = credit_used < DEPTH_W;
    assign out_valid   = fifo_count != '0;
    assign pop         = out_valid && out_ready;
    assign out_last    = out_valid && (pix_cnt == LAST_C);
    assign rq          = sat_round({{(64 - ACC_W){acc_in[ACC_W-1]}}, acc_in}, FRAC, OUT_W, relu_en);

    // Every result leaving the requant stage retires its credit, even when the
    // FIFO drops it; issues beyond the budget saturate so the count never overflows.
    always_comb begin
        infl_next = {1'b0, inflight} + (CW + 1)'(issue);
        if (q_valid && (infl_next != '0)) begin
            infl_next = infl_next - 1'b1;
        end
        if (infl_next > DEPTH_W) begin
            infl_next = DEPTH_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= '0;
            q_valid   <= 1'b0;
            q_data    <= '0;
            pix_cnt   <= '0;
            err_ovf   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            inflight <= infl_next[CW-1:0];
            q_valid  <= acc_valid;
            if (acc_valid) begin
                q_data <= rq[OUT_W-1:0];
            end
            if (pop) begin
                pix_cnt <= (pix_cnt == LAST_C) ? '0 : pix_cnt + 1'b1;
            end
            if (issue && !issue_ready) begin
                err_proto <= 1'b1;
            end
            if (drop) begin
                err_ovf <= 1'b1;
            end
        end
    end

    conv_drain_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (q_valid),
        .push_data (q_data),
        .pop       (pop),
        .rd_data   (out_data),
        .count     (fifo_count),
        .push_drop (drop)
    );

endmodule

// File: tb/tb_conv_result_drain.sv
// tb/tb_conv_result_drain.sv - scoreboard bench for conv_result_drain with a 10-cycle core model
module tb_conv_result_drain;

    localparam int FP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue;
    logic        issue_ready;
    logic [38:0] acc_in;
    logic        acc_valid;
    logic        relu_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        err_ovf;
    logic        err_proto;

    logic [38:0] issue_val;
    logic [38:0] pd [10];
    logic [9:0]  pv;
    logic [7:0]  exp_q [$];
    int          pix_cnt;
    int          n_last;
    int          n_chk;
    int          n_bad;

    always #5 clk = ~clk;

    conv_result_drain #(
        .ACC_W     (39),
        .FRAC      (16),
        .OUT_W     (8),
        .DEPTH     (16),
        .FRAME_PIX (FP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .issue_ready (issue_ready),
        .acc_in      (acc_in),
        .acc_valid   (acc_valid),
        .relu_en     (relu_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .err_ovf     (err_ovf),
        .err_proto   (err_proto)
    );

    // Core stand-in: each issue yields its accumulator 10 cycles later; reset flushes it.
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[8:0], issue};
            pd[0] <= issue_val;
            for (int i = 1; i < 10; i++) pd[i] <= pd[i-1];
        end
    end
    assign acc_valid = pv[9];
    assign acc_in    = pd[9];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_q(input longint a, input bit relu);
        longint r;
        r = (a + 32768) >>> 16;
        if (relu) begin
            if (r < 0) r = 0;
            if (r > 255) r = 255;
        end else begin
            if (r < -128) r = -128;
            if (r > 127) r = 127;
        end
        return r[7:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_bad++;
                $error("FAIL pop_unexpected observed=%0h expected=none", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
                chk("out_last", out_last, (pix_cnt == FP - 1));
            end
            if (out_last) n_last++;
            pix_cnt = (pix_cnt + 1) % FP;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        pix_cnt = 0;
    endtask

    // Leaves issue high so consecutive calls are back-to-back.
    task automatic issue_exp(input longint a, input logic [7:0] e, input bit keep);
        issue     = 1'b1;
        issue_val = a[38:0];
        if (keep) exp_q.push_back(e);
        tick();
    endtask

    task automatic issue_m(input longint a);
        issue_exp(a, ref_q(a, relu_en), 1'b1);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_within_bound", (n < bound), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint a;
        n_chk = 0; n_bad = 0; n_last = 0; pix_cnt = 0;
        issue = 1'b0; issue_val = '0; relu_en = 1'b0; out_ready = 1'b0; rst = 1'b1;
        tick();
        do_reset();
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_err_proto", err_proto, 0);

        // Requantization, signed then ReLU
        out_ready = 1'b1;
        relu_en   = 1'b0;
        issue_exp(229376, 8'd4, 1'b1);
        issue_exp(-5 * 65536, 8'hFB, 1'b1);
        issue_exp(1000 * 65536, 8'h7F, 1'b1);
        issue_exp(-1000 * 65536, 8'h80, 1'b1);
        for (int i = 0; i < 6; i++) begin
            a = longint'($urandom_range(0, 800 * 65536)) - 400 * 65536;
            issue_m(a);
        end
        issue = 1'b0;
        wait_drain(40);
        relu_en = 1'b1;
        issue_exp(300 * 65536, 8'd255, 1'b1);
        issue_exp(-5 * 65536, 8'd0, 1'b1);
        issue_exp(32767, 8'd0, 1'b1);
        issue_exp(32768, 8'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            a = longint'($urandom_range(0, 800 * 65536)) - 400 * 65536;
            issue_m(a);
        end
        issue = 1'b0;
        wait_drain(40);

        // Credit exhaustion with a stalled consumer
        do_reset();
        out_ready = 1'b0;
        relu_en   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            issue_m(longint'(i) * 65536);
            if (i == 14) chk("credit_after_15", issue_ready, 1);
        end
        issue = 1'b0;
        chk("credit_after_16", issue_ready, 0);
        repeat (12) tick();
        chk("credit_full_out_valid", out_valid, 1);
        chk("credit_full_ready", issue_ready, 0);
        chk("credit_full_no_ovf", err_ovf, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("credit_after_pop", issue_ready, 1);
        out_ready = 1'b1;
        wait_drain(40);
        chk("credit_no_ovf", err_ovf, 0);
        chk("credit_no_proto", err_proto, 0);

        // Issue beyond the budget
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) issue_exp(longint'(i + 20) * 65536, 8'(i + 20), (i < 16));
        issue = 1'b0;
        chk("proto_set", err_proto, 1);
        repeat (12) tick();
        chk("ovf_set", err_ovf, 1);
        out_ready = 1'b1;
        wait_drain(40);
        chk("proto_ready_back", issue_ready, 1);

        // Reset with results both buffered and in flight
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) issue_m(longint'(i) * 65536);
        issue = 1'b0;
        repeat (8) tick();
        chk("mid_buffered", out_valid, 1);
        chk("mid_ovf_sticky", err_ovf, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_issue_ready", issue_ready, 1);
        chk("mid_rst_err_ovf", err_ovf, 0);
        chk("mid_rst_err_proto", err_proto, 0);
        rst = 1'b0;
        exp_q.delete();
        pix_cnt = 0;
        repeat (16) tick();
        chk("mid_quiet_after_rst", out_valid, 0);

        // Frame marking
        do_reset();
        out_ready = 1'b1;
        n_last    = 0;
        for (int i = 0; i < 8; i++) issue_m(longint'(i * 3) * 65536);
        issue = 1'b0;
        wait_drain(40);
        chk("frame_last_count", n_last, 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
